// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared defaults, index type and saturating counter update for bp_counter_table
package bp_pkg;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int INDEX_BITS_DEF = 7;
  localparam int CTR_BITS_DEF   = 2;
  localparam int HIST_BITS_DEF  = 7;
  localparam int STAT_BITS_DEF  = 32;

  typedef logic [INDEX_BITS_DEF-1:0] bp_idx_t;

  // Counter values are carried zero-extended to 32 bits so one function serves every CTR_BITS.
  function automatic logic [31:0] ctr_next(input logic [31:0] ctr, input logic taken,
                                           input int ctr_bits = CTR_BITS_DEF);
    logic [31:0] ctr_max;
    ctr_max = (32'd1 << ctr_bits) - 32'd1;
    if (taken)
      return (ctr >= ctr_max) ? ctr_max : ctr + 32'd1;
    return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
  endfunction
endpackage

// File: rtl/bp_counter_table_if.sv
// rtl/bp_counter_table_if.sv - decoder lookup, ROB training, fetch/dispatch outputs and statistics
interface bp_counter_table_if import bp_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int STAT_BITS  = STAT_BITS_DEF
);
  logic                  rdy_in;
  logic                  decoder_bp_en_in;
  logic [ADDR_WIDTH-1:0] decoder_bp_pc_in;
  logic [ADDR_WIDTH-1:0] decoder_bp_target_in;
  logic                  bp_if_en_out;
  logic [ADDR_WIDTH-1:0] bp_if_pc_out;
  logic                  bp_instqueue_rst_out;
  logic                  bp_dispatcher_taken_out;
  logic [INDEX_BITS-1:0] bp_dispatcher_idx_out;
  logic                  rob_bp_en_in;
  logic                  rob_bp_taken_in;
  logic                  rob_bp_correct_in;
  logic [INDEX_BITS-1:0] rob_bp_idx_in;
  logic [STAT_BITS-1:0]  bp_stat_branches_out;
  logic [STAT_BITS-1:0]  bp_stat_mispred_out;

  modport master (
    output rdy_in, decoder_bp_en_in, decoder_bp_pc_in, decoder_bp_target_in,
           rob_bp_en_in, rob_bp_taken_in, rob_bp_correct_in, rob_bp_idx_in,
    input  bp_if_en_out, bp_if_pc_out, bp_instqueue_rst_out, bp_dispatcher_taken_out,
           bp_dispatcher_idx_out, bp_stat_branches_out, bp_stat_mispred_out
  );

  modport slave (
    input  rdy_in, decoder_bp_en_in, decoder_bp_pc_in, decoder_bp_target_in,
           rob_bp_en_in, rob_bp_taken_in, rob_bp_correct_in, rob_bp_idx_in,
    output bp_if_en_out, bp_if_pc_out, bp_instqueue_rst_out, bp_dispatcher_taken_out,
           bp_dispatcher_idx_out, bp_stat_branches_out, bp_stat_mispred_out
  );
endinterface

// File: rtl/bp_sat_ctr_array.sv
// rtl/bp_sat_ctr_array.sv - saturating counter storage: async reset, combinational read, clocked write
module bp_sat_ctr_array import bp_pkg::*; #(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int CTR_BITS   = CTR_BITS_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [CTR_BITS-1:0]   rd_ctr,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_taken
);
  localparam int DEPTH = 1 << INDEX_BITS;
  // Weakly not-taken: one below the taken threshold.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0] ctr_mem [DEPTH];
  logic [CTR_BITS-1:0] wr_next;

  assign rd_ctr  = ctr_mem[rd_idx];
  assign wr_next = CTR_BITS'(ctr_next(32'(ctr_mem[wr_idx]), wr_taken, CTR_BITS));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++)
        ctr_mem[i] <= CTR_INIT;
    end else if (wr_en) begin
      ctr_mem[wr_idx] <= wr_next;
    end
  end
endmodule

// File: rtl/bp_counter_table.sv
// rtl/bp_counter_table.sv - direction predictor top: index hashing, history, statistics, output muxing
// Optional BP_GSHARE_EN: XOR commit-time global history into the lookup index.
module bp_counter_table import bp_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int CTR_BITS   = CTR_BITS_DEF,
  parameter int HIST_BITS  = HIST_BITS_DEF,
  parameter int STAT_BITS  = STAT_BITS_DEF
) (
  input logic              clk_in,
  input logic              rst_in,
  bp_counter_table_if.slave bus
);
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  logic                  lookup_en;
  logic                  train_en;
  logic                  pred_taken;
  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [CTR_BITS-1:0]   lookup_ctr;
  logic [STAT_BITS-1:0]  stat_branches;
  logic [STAT_BITS-1:0]  stat_mispred;
  logic                  unused_pc;

  // Outputs are forced inactive while reset is held, not just after it.
  assign lookup_en = bus.decoder_bp_en_in & bus.rdy_in & ~rst_in;
  assign train_en  = bus.rob_bp_en_in & bus.rdy_in;
  assign pc_idx    = bus.decoder_bp_pc_in[INDEX_BITS+1:2];
  assign unused_pc = ^{bus.decoder_bp_pc_in[ADDR_WIDTH-1:INDEX_BITS+2], bus.decoder_bp_pc_in[1:0]};

`ifdef BP_GSHARE_EN
  logic [HIST_BITS-1:0] history;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      history <= '0;
    else if (train_en)
      history <= {history[HIST_BITS-2:0], bus.rob_bp_taken_in};
  end

  assign lookup_idx = pc_idx ^ INDEX_BITS'(history);
`else
  assign lookup_idx = pc_idx;
`endif

  bp_sat_ctr_array #(
    .INDEX_BITS(INDEX_BITS),
    .CTR_BITS  (CTR_BITS)
  ) u_ctr_array (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rd_idx  (lookup_idx),
    .rd_ctr  (lookup_ctr),
    .wr_en   (train_en),
    .wr_idx  (bus.rob_bp_idx_in),
    .wr_taken(bus.rob_bp_taken_in)
  );

  assign pred_taken = lookup_en & lookup_ctr[CTR_BITS-1];

  assign bus.bp_if_en_out            = pred_taken;
  assign bus.bp_instqueue_rst_out    = pred_taken;
  assign bus.bp_dispatcher_taken_out = pred_taken;
  assign bus.bp_if_pc_out            = pred_taken ? bus.decoder_bp_target_in : '0;
  assign bus.bp_dispatcher_idx_out   = lookup_en ? lookup_idx : '0;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (train_en) begin
      if (stat_branches != STAT_MAX)
        stat_branches <= stat_branches + STAT_BITS'(1);
      if (!bus.rob_bp_correct_in && stat_mispred != STAT_MAX)
        stat_mispred <= stat_mispred + STAT_BITS'(1);
    end
  end

  assign bus.bp_stat_branches_out = stat_branches;
  assign bus.bp_stat_mispred_out  = stat_mispred;
endmodule

// File: tb/tb_bp_counter_table.sv
// tb/tb_bp_counter_table.sv - directed and randomized checks of bp_counter_table against a behavioural model
module tb_bp_counter_table;
  localparam int AW    = 32;
  localparam int IB    = 7;
  localparam int CB    = 2;
  localparam int HB    = 7;
  localparam int SB    = 6;
  localparam int CMAX  = (1 << CB) - 1;
  localparam int CHALF = 1 << (CB - 1);
  localparam int SMAX  = (1 << SB) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   done = 1'b0;

  bp_counter_table_if #(.ADDR_WIDTH(AW), .INDEX_BITS(IB), .STAT_BITS(SB)) bus ();

  bp_counter_table #(
    .ADDR_WIDTH(AW), .INDEX_BITS(IB), .CTR_BITS(CB), .HIST_BITS(HB), .STAT_BITS(SB)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int m_ctr [1 << IB];
  int m_br;
  int m_mis;
  int m_hist;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    int i;
    i = int'(pc / 4) % (1 << IB);
`ifdef BP_GSHARE_EN
    i = i ^ m_hist;
`endif
    return i;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_ctr[i]) m_ctr[i] <= CHALF - 1;
      m_br   <= 0;
      m_mis  <= 0;
      m_hist <= 0;
    end else if (bus.rob_bp_en_in && bus.rdy_in) begin
      if (bus.rob_bp_taken_in)
        m_ctr[bus.rob_bp_idx_in] <= (m_ctr[bus.rob_bp_idx_in] >= CMAX) ? CMAX : m_ctr[bus.rob_bp_idx_in] + 1;
      else
        m_ctr[bus.rob_bp_idx_in] <= (m_ctr[bus.rob_bp_idx_in] <= 0) ? 0 : m_ctr[bus.rob_bp_idx_in] - 1;
      m_br <= (m_br >= SMAX) ? SMAX : m_br + 1;
      if (!bus.rob_bp_correct_in)
        m_mis <= (m_mis >= SMAX) ? SMAX : m_mis + 1;
      m_hist <= ((m_hist * 2) + (bus.rob_bp_taken_in ? 1 : 0)) % (1 << HB);
    end
  end

  always @(negedge clk) begin
    bit en;
    bit t;
    int idx;
    if (!done) begin
      en  = bus.decoder_bp_en_in && bus.rdy_in && !rst;
      idx = m_idx(bus.decoder_bp_pc_in);
      t   = en && (m_ctr[idx] >= CHALF);
      chk("if_en", 64'(bus.bp_if_en_out), 64'(t));
      chk("iq_rst", 64'(bus.bp_instqueue_rst_out), 64'(t));
      chk("disp_taken", 64'(bus.bp_dispatcher_taken_out), 64'(t));
      chk("if_pc", 64'(bus.bp_if_pc_out), t ? 64'(bus.decoder_bp_target_in) : 64'd0);
      chk("disp_idx", 64'(bus.bp_dispatcher_idx_out), en ? 64'(idx) : 64'd0);
      chk("stat_br", 64'(bus.bp_stat_branches_out), 64'(m_br));
      chk("stat_mis", 64'(bus.bp_stat_mispred_out), 64'(m_mis));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input int idx, input bit taken, input bit correct);
    bus.rob_bp_en_in      = 1'b1;
    bus.rob_bp_idx_in     = IB'(idx);
    bus.rob_bp_taken_in   = taken;
    bus.rob_bp_correct_in = correct;
    tick();
    bus.rob_bp_en_in = 1'b0;
  endtask

  initial begin
    bus.rdy_in               = 1'b1;
    bus.decoder_bp_en_in     = 1'b0;
    bus.decoder_bp_pc_in     = '0;
    bus.decoder_bp_target_in = '0;
    bus.rob_bp_en_in         = 1'b0;
    bus.rob_bp_taken_in      = 1'b0;
    bus.rob_bp_correct_in    = 1'b1;
    bus.rob_bp_idx_in        = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    bus.decoder_bp_en_in     = 1'b1;
    bus.decoder_bp_pc_in     = 32'h100;
    bus.decoder_bp_target_in = 32'h200;
    #3;
    chk("lit_rst_taken", 64'(bus.bp_dispatcher_taken_out), 64'd0);
    chk("lit_rst_if_en", 64'(bus.bp_if_en_out), 64'd0);
    chk("lit_rst_idx", 64'(bus.bp_dispatcher_idx_out), 64'h40);
    chk("lit_rst_br", 64'(bus.bp_stat_branches_out), 64'd0);
    chk("lit_rst_mis", 64'(bus.bp_stat_mispred_out), 64'd0);
    tick();

`ifndef BP_GSHARE_EN
    train('h40, 1'b1, 1'b1);
    #3;
    chk("lit_t1_taken", 64'(bus.bp_dispatcher_taken_out), 64'd1);
    chk("lit_t1_pc", 64'(bus.bp_if_pc_out), 64'h200);
    chk("lit_t1_iq", 64'(bus.bp_instqueue_rst_out), 64'd1);
    tick();

    repeat (5) train('h40, 1'b1, 1'b1);
    chk("lit_model_sat", 64'(m_ctr['h40]), 64'd3);
    train('h40, 1'b0, 1'b0);
    #3;
    chk("lit_sat_nt_taken", 64'(bus.bp_dispatcher_taken_out), 64'd1);
    chk("lit_br7", 64'(bus.bp_stat_branches_out), 64'd7);
    chk("lit_mis1", 64'(bus.bp_stat_mispred_out), 64'd1);
    tick();

    train('h40, 1'b0, 1'b1);
    bus.rob_bp_en_in      = 1'b1;
    bus.rob_bp_idx_in     = IB'('h40);
    bus.rob_bp_taken_in   = 1'b1;
    bus.rob_bp_correct_in = 1'b1;
    #3;
    chk("lit_same_pre", 64'(bus.bp_dispatcher_taken_out), 64'd0);
    tick();
    bus.rob_bp_en_in = 1'b0;
    #3;
    chk("lit_same_post", 64'(bus.bp_dispatcher_taken_out), 64'd1);
    tick();

    bus.rdy_in            = 1'b0;
    bus.rob_bp_en_in      = 1'b1;
    bus.rob_bp_taken_in   = 1'b0;
    bus.rob_bp_correct_in = 1'b0;
    #3;
    chk("lit_rdy_taken", 64'(bus.bp_dispatcher_taken_out), 64'd0);
    chk("lit_rdy_if_en", 64'(bus.bp_if_en_out), 64'd0);
    chk("lit_rdy_pc", 64'(bus.bp_if_pc_out), 64'd0);
    chk("lit_rdy_idx", 64'(bus.bp_dispatcher_idx_out), 64'd0);
    tick();
    tick();
    bus.rdy_in       = 1'b1;
    bus.rob_bp_en_in = 1'b0;
    #3;
    chk("lit_rdy_hold_taken", 64'(bus.bp_dispatcher_taken_out), 64'd1);
    chk("lit_rdy_hold_br", 64'(bus.bp_stat_branches_out), 64'd9);
    chk("lit_rdy_hold_mis", 64'(bus.bp_stat_mispred_out), 64'd1);
    tick();
`else
    train('h10, 1'b1, 1'b1);
    train('h11, 1'b1, 1'b1);
    train('h12, 1'b0, 1'b0);
    #3;
    chk("lit_gs_idx", 64'(bus.bp_dispatcher_idx_out), 64'h46);
    chk("lit_gs_mis", 64'(bus.bp_stat_mispred_out), 64'd1);
    tick();
`endif

    repeat (SMAX + 3) train(int'($urandom_range(127)), 1'($urandom_range(1)), 1'b0);
    #3;
    chk("lit_mis_sat", 64'(bus.bp_stat_mispred_out), 64'(SMAX));
    chk("lit_br_sat", 64'(bus.bp_stat_branches_out), 64'(SMAX));
    tick();

    for (int c = 0; c < 3000; c++) begin
      rst                      = ($urandom_range(399) == 0);
      bus.rdy_in               = ($urandom_range(9) != 0);
      bus.decoder_bp_en_in     = 1'($urandom_range(1));
      bus.decoder_bp_pc_in     = ($urandom & ~32'h1FC) | (32'($urandom_range(15)) << 2);
      bus.decoder_bp_target_in = $urandom;
      bus.rob_bp_en_in         = 1'($urandom_range(1));
      bus.rob_bp_taken_in      = 1'($urandom_range(1));
      bus.rob_bp_correct_in    = ($urandom_range(3) != 0);
      bus.rob_bp_idx_in        = ($urandom_range(7) == 0) ? IB'($urandom_range(127)) : IB'($urandom_range(15));
      tick();
    end

    rst  = 1'b0;
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
